// File: rtl/clk_gate_ctrl_pkg.sv
// Shared types and sizing helpers for the per-domain clock-gating sequencer.
package clk_gate_ctrl_pkg;

    // Per-domain sequencer state.
    typedef enum logic [1:0] {
        CG_ON    = 2'd0,
        CG_DRAIN = 2'd1,
        CG_OFF   = 2'd2,
        CG_WAKE  = 2'd3
    } cg_state_e;

    // Width of a counter that must be able to hold the value x.
    function automatic int cg_cnt_w(input int x);
        return $clog2(x + 1);
    endfunction

    // Counter widths for the default configuration.
    localparam int IDLE_CNT_W_DEF  = $clog2(16 + 1);
    localparam int DRAIN_CNT_W_DEF = $clog2(64 + 1);
    localparam int WAKE_CNT_W_DEF  = $clog2(2 + 1);

endpackage

// File: rtl/clk_gate_ctrl_fsm.sv
// One domain's gating sequencer: idle qualification, stop handshake with
// drain timeout, settle window on wake, and the sticky drain-timeout flag.
module clk_gate_ctrl_fsm
    import clk_gate_ctrl_pkg::*;
#(
    parameter int IdleCycles   = 16,
    parameter int WakeCycles   = 2,
    parameter int DrainTimeout = 64
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic sw_en_i,
    input  logic auto_en_i,
    input  logic idle_i,
    input  logic wake_i,
    input  logic stop_ack_i,
    output logic cg_en_o,
    output logic stop_req_o,
    output logic ready_o,
    output logic err_o
);

    localparam int IW  = cg_cnt_w(IdleCycles);
    localparam int DW  = cg_cnt_w(DrainTimeout);
    localparam int WW  = cg_cnt_w(WakeCycles);
    // DRAIN and WAKE never overlap, so they share one counter.
    localparam int CW  = (DW > WW) ? DW : WW;

    localparam logic [IW-1:0] IDLE_LAST  = IW'(IdleCycles - 1);
    localparam logic [IW-1:0] IDLE_SAT   = IW'(IdleCycles);
    localparam logic [CW-1:0] DRAIN_LAST = CW'(DrainTimeout - 1);
    localparam logic [CW-1:0] WAKE_LAST  = CW'(WakeCycles - 1);
    localparam logic [CW-1:0] CNT_SAT    = {CW{1'b1}};

    cg_state_e       state_q, state_d;
    logic [IW-1:0]   idle_cnt_q, idle_cnt_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            err_q, err_d;
    logic            cg_en_q, stop_req_q, ready_q;
    logic            cg_en_d, stop_req_d, ready_d;
    logic            want_on;
    logic            idle_qual;

    // Saturating increment of the idle counter.
    function automatic logic [IW-1:0] idle_inc(input logic [IW-1:0] v);
        return (v == IDLE_SAT) ? v : v + 1'b1;
    endfunction

    // Saturating increment of the shared drain/wake counter.
    function automatic logic [CW-1:0] cnt_inc(input logic [CW-1:0] v);
        return (v == CNT_SAT) ? v : v + 1'b1;
    endfunction

    assign want_on   = sw_en_i & (wake_i | ~auto_en_i);
    assign idle_qual = auto_en_i & idle_i & ~wake_i;

    // State, counters, sticky error and registered outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= CG_ON;
            idle_cnt_q <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            cg_en_q    <= 1'b1;
            stop_req_q <= 1'b0;
            ready_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            idle_cnt_q <= idle_cnt_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            cg_en_q    <= cg_en_d;
            stop_req_q <= stop_req_d;
            ready_q    <= ready_d;
        end
    end

    // Next-state and counter logic; outputs decoded from the next state so
    // they land in registers on the same edge as the state.
    always_comb begin
        state_d    = state_q;
        idle_cnt_d = '0;
        cnt_d      = '0;
        err_d      = err_q;
        case (state_q)
            CG_ON: begin
                if (idle_qual) begin
                    idle_cnt_d = idle_inc(idle_cnt_q);
                end
                if (!sw_en_i || (idle_qual && idle_cnt_q == IDLE_LAST)) begin
                    state_d    = CG_DRAIN;
                    idle_cnt_d = '0;
                end
            end
            CG_DRAIN: begin
                // Abort wins over ack: the clock never stopped, so no settle.
                if (want_on) begin
                    state_d = CG_ON;
                end else if (stop_ack_i) begin
                    state_d = CG_OFF;
                end else if (cnt_q == DRAIN_LAST) begin
                    state_d = CG_ON;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_inc(cnt_q);
                end
            end
            CG_OFF: begin
                if (want_on) begin
                    state_d = CG_WAKE;
                end
            end
            CG_WAKE: begin
                if (cnt_q == WAKE_LAST) begin
                    state_d = CG_ON;
                end else begin
                    cnt_d = cnt_inc(cnt_q);
                end
            end
            default: begin
                state_d = CG_ON;
            end
        endcase

        cg_en_d    = 1'b1;
        stop_req_d = 1'b0;
        ready_d    = 1'b0;
        case (state_d)
            CG_ON:    ready_d    = 1'b1;
            CG_DRAIN: stop_req_d = 1'b1;
            CG_OFF: begin
                cg_en_d    = 1'b0;
                stop_req_d = 1'b1;
            end
            default:  ready_d    = 1'b0;
        endcase
    end

    assign cg_en_o    = cg_en_q;
    assign stop_req_o = stop_req_q;
    assign ready_o    = ready_q;
    assign err_o      = err_q;

endmodule

// File: rtl/clk_gate_ctrl.sv
// Clock-gating sequencer top: one independent FSM per domain, with scan
// test mode forcing every gate enable high without disturbing the FSMs.
module clk_gate_ctrl
    import clk_gate_ctrl_pkg::*;
#(
    parameter int NumDomains   = 4,
    parameter int IdleCycles   = 16,
    parameter int WakeCycles   = 2,
    parameter int DrainTimeout = 64
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [NumDomains-1:0] sw_en_i,
    input  logic [NumDomains-1:0] auto_en_i,
    input  logic [NumDomains-1:0] idle_i,
    input  logic [NumDomains-1:0] wake_i,
    input  logic [NumDomains-1:0] stop_ack_i,
    input  logic                  test_mode_i,
    output logic [NumDomains-1:0] cg_en_o,
    output logic [NumDomains-1:0] stop_req_o,
    output logic [NumDomains-1:0] ready_o,
    output logic [NumDomains-1:0] err_o
);

    logic [NumDomains-1:0] cg_en_fsm;

    for (genvar d = 0; d < NumDomains; d++) begin : g_dom
        clk_gate_ctrl_fsm #(
            .IdleCycles   (IdleCycles),
            .WakeCycles   (WakeCycles),
            .DrainTimeout (DrainTimeout)
        ) u_fsm (
            .clk_i      (clk_i),
            .rst_i      (rst_i),
            .sw_en_i    (sw_en_i[d]),
            .auto_en_i  (auto_en_i[d]),
            .idle_i     (idle_i[d]),
            .wake_i     (wake_i[d]),
            .stop_ack_i (stop_ack_i[d]),
            .cg_en_o    (cg_en_fsm[d]),
            .stop_req_o (stop_req_o[d]),
            .ready_o    (ready_o[d]),
            .err_o      (err_o[d])
        );
    end

    // Scan override is deliberately combinational so it takes effect at once.
    assign cg_en_o = cg_en_fsm | {NumDomains{test_mode_i}};

endmodule
